ternary_seq_ctrl: RTL and testbench
===================================

Name: ternary_seq_ctrl

Overview:
Top-level sequencer for the ternary matrix-vector engine. On a start command it steps the engine through three phases: weight load (drives the weight loader's enable and chunk index), compute (streams input indices into the MAC array) and output (serializes per-output results under a valid/ready handshake). It sits between the chip pin interface and the loader/MAC/output-mux datapath, and is the only block that decides which phase the datapath is in.

Parameters:
MAX_IN_LEN, 16, maximum input-vector length (columns)
MAX_OUT_LEN, 8, maximum output-vector length (rows)
WIDTH, 2, bits per ternary weight; also the number of load chunks per row
IN_BITS, $clog2(MAX_IN_LEN), width of the input-length config and compute index
OUT_BITS, $clog2(MAX_OUT_LEN), width of the output-length config and output select
WIDTH_BITS, $clog2(WIDTH), extra low-order bits of the load index

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
ena  input  1  global enable; low freezes the state and all counters
i_start  input  1  start one job; sampled only in IDLE
i_abort  input  1  return to IDLE from any state; no done pulse
i_cfg_in  input  IN_BITS  input length minus 1; latched on accepted start
i_cfg_out  input  OUT_BITS  output length minus 1; latched on accepted start
o_load_en  output  1  weight loader write enable
o_load_idx  output  OUT_BITS+WIDTH_BITS  loader chunk index = {row, chunk}
o_mac_en  output  1  MAC accumulate enable
o_mac_clr  output  1  clear accumulators; high only on the first COMPUTE cycle
o_mac_idx  output  IN_BITS  current input column
o_out_valid  output  1  result beat valid
i_out_ready  input  1  consumer accepts the beat
o_out_sel  output  OUT_BITS  output row being presented
o_busy  output  1  state != IDLE
o_done  output  1  single-cycle pulse after the last output beat

Behaviour:
- All outputs are registered. On reset: state IDLE, config registers 0, and every output 0.
- States: IDLE, LOAD, COMPUTE, OUTPUT, DONE. All transitions and counter updates require ena=1.
- IDLE: when i_start=1, latch the config, go to LOAD, and reset the shared counter to 0. o_load_en=1 and o_load_idx=0 are visible in the cycle after the start edge.
- LOAD: o_load_idx increments once per cycle.
  - Last index = {cfg_out, {WIDTH_BITS{1}}}, i.e. (cfg_out+1)*WIDTH chunks in total.
  - After the cycle showing the last index: go to COMPUTE and reset the counter to 0.
- COMPUTE: o_mac_en=1, and o_mac_idx runs 0..cfg_in, one per cycle. o_mac_clr=1 only in the cycle where o_mac_idx=0. After cfg_in, go to OUTPUT with sel=0.
- OUTPUT:
  - o_out_valid=1 and o_out_sel holds its value until an edge with o_out_valid & i_out_ready; then sel increments.
  - The handshake at sel=cfg_out moves to DONE.
  - o_out_valid must stay high and o_out_sel must stay stable while i_out_ready=0.
- DONE: o_done=1 for one cycle, then IDLE. o_busy drops in the same cycle o_done drops.
- ena=0: state, counters and config hold. o_load_en, o_mac_en, o_mac_clr and o_out_valid are forced 0 in the following cycle; indices hold. When ena returns, the datapath resumes at the same index with no skip and no repeat.
- i_abort=1 (with ena=1): the next state is IDLE and all enables/valid go to 0 the next cycle. Abort has priority over start and over every phase transition.
- i_start outside IDLE is ignored. Config changes outside IDLE are ignored.
- Counters never wrap within a phase; the terminal compare ends the phase first. Minimum job (cfg_in=0, cfg_out=0): WIDTH load cycles, 1 compute cycle, 1 output beat.
- rst_n low mid-job: next cycle matches the reset values, with no done pulse.

Test Plan:
- Defaults, cfg_in=15, cfg_out=7, ready tied 1, start at edge 0 -> o_load_idx 0..15 in cycles 1-16; o_mac_idx 0..15 in cycles 17-32 with o_mac_clr only at 17; o_out_sel 0..7 in cycles 33-40; o_done only at 41; o_busy 1 in cycles 1-41.
- Minimum job, cfg_in=0, cfg_out=0 -> load idx 0,1; one compute cycle with clr=1 and en=1; one output beat; done 4 cycles after the load phase starts.
- Backpressure: ready=0 for 3 cycles at sel=2 -> valid stays 1, sel stays 2; each index is presented until its handshake; done is delayed by exactly 3 cycles.
- ena=0 for 2 cycles at load idx 5 -> o_load_en=0, idx holds 5; on resume the sequence continues 5,6,...; total job length +2 cycles.
- i_abort at compute idx 4 -> IDLE next cycle, all enables 0, no o_done. A new start then runs a full clean job from load idx 0.
- i_start pulsed during COMPUTE with different config -> ignored; the job completes with the original config. rst_n low during OUTPUT -> all outputs 0 next cycle, no o_done.

Source files
------------

// File: rtl/ternary_seq_ctrl.sv
// Phase sequencer for the ternary MV engine: IDLE -> LOAD -> COMPUTE -> OUTPUT -> DONE.
// All outputs registered; OUTPUT advances only on valid&ready, ena=0 freezes everything.
`timescale 1ns/1ps
module ternary_seq_ctrl #(
  parameter int MAX_IN_LEN  = 16,
  parameter int MAX_OUT_LEN = 8,
  parameter int WIDTH       = 2,
  parameter int IN_BITS     = $clog2(MAX_IN_LEN),
  parameter int OUT_BITS    = $clog2(MAX_OUT_LEN),
  parameter int WIDTH_BITS  = $clog2(WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic                         i_start,
  input  logic                         i_abort,
  input  logic [IN_BITS-1:0]           i_cfg_in,
  input  logic [OUT_BITS-1:0]          i_cfg_out,
  output logic                         o_load_en,
  output logic [OUT_BITS+WIDTH_BITS-1:0] o_load_idx,
  output logic                         o_mac_en,
  output logic                         o_mac_clr,
  output logic [IN_BITS-1:0]           o_mac_idx,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [OUT_BITS-1:0]          o_out_sel,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int LOAD_W = OUT_BITS + WIDTH_BITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_OUTPUT,
    S_DONE
  } state_t;

  state_t              state;
  logic [IN_BITS-1:0]  cfg_in;
  logic [OUT_BITS-1:0] cfg_out;
  logic [LOAD_W-1:0]   last_load;

  // Every chunk of the last configured row.
  assign last_load = {cfg_out, {WIDTH_BITS{1'b1}}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cfg_in      <= '0;
      cfg_out     <= '0;
      o_load_en   <= 1'b0;
      o_load_idx  <= '0;
      o_mac_en    <= 1'b0;
      o_mac_clr   <= 1'b0;
      o_mac_idx   <= '0;
      o_out_valid <= 1'b0;
      o_out_sel   <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else if (!ena) begin
      // Freeze: indices and state hold, datapath strobes drop.
      o_load_en   <= 1'b0;
      o_mac_en    <= 1'b0;
      o_mac_clr   <= 1'b0;
      o_out_valid <= 1'b0;
    end else if (i_abort) begin
      state       <= S_IDLE;
      o_load_en   <= 1'b0;
      o_mac_en    <= 1'b0;
      o_mac_clr   <= 1'b0;
      o_out_valid <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            cfg_in     <= i_cfg_in;
            cfg_out    <= i_cfg_out;
            state      <= S_LOAD;
            o_load_en  <= 1'b1;
            o_load_idx <= '0;
            o_busy     <= 1'b1;
          end
        end
        S_LOAD: begin
          if (o_load_idx == last_load) begin
            state     <= S_COMPUTE;
            o_load_en <= 1'b0;
            o_mac_en  <= 1'b1;
            o_mac_clr <= 1'b1;
            o_mac_idx <= '0;
          end else begin
            o_load_en  <= 1'b1;
            o_load_idx <= o_load_idx + LOAD_W'(1);
          end
        end
        S_COMPUTE: begin
          o_mac_clr <= 1'b0;
          if (o_mac_idx == cfg_in) begin
            state       <= S_OUTPUT;
            o_mac_en    <= 1'b0;
            o_out_valid <= 1'b1;
            o_out_sel   <= '0;
          end else begin
            o_mac_en  <= 1'b1;
            o_mac_idx <= o_mac_idx + IN_BITS'(1);
          end
        end
        S_OUTPUT: begin
          // Valid is re-raised after a freeze; only a real handshake advances sel.
          o_out_valid <= 1'b1;
          if (o_out_valid && i_out_ready) begin
            if (o_out_sel == cfg_out) begin
              state       <= S_DONE;
              o_out_valid <= 1'b0;
              o_done      <= 1'b1;
            end else begin
              o_out_sel <= o_out_sel + OUT_BITS'(1);
            end
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          o_done <= 1'b0;
          o_busy <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ternary_seq_ctrl.sv
// Directed bench for ternary_seq_ctrl: cycle-by-cycle phase timelines with stalls, freezes, abort and reset.
`timescale 1ns/1ps
module tb_ternary_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       i_start;
  logic       i_abort;
  logic [3:0] i_cfg_in;
  logic [2:0] i_cfg_out;
  logic       o_load_en;
  logic [3:0] o_load_idx;
  logic       o_mac_en;
  logic       o_mac_clr;
  logic [3:0] o_mac_idx;
  logic       o_out_valid;
  logic       i_out_ready;
  logic [2:0] o_out_sel;
  logic       o_busy;
  logic       o_done;

  int errors = 0;
  int checks = 0;

  ternary_seq_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_cfg_in    (i_cfg_in),
    .i_cfg_out   (i_cfg_out),
    .o_load_en   (o_load_en),
    .o_load_idx  (o_load_idx),
    .o_mac_en    (o_mac_en),
    .o_mac_clr   (o_mac_clr),
    .o_mac_idx   (o_mac_idx),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_sel   (o_out_sel),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Negative expectation means "don't care".
  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    if (exp >= 0) begin
      checks++;
      assert (obs === 32'(exp)) else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " load_en"},   32'(o_load_en),   0);
    chk({tag, " load_idx"},  32'(o_load_idx),  0);
    chk({tag, " mac_en"},    32'(o_mac_en),    0);
    chk({tag, " mac_clr"},   32'(o_mac_clr),   0);
    chk({tag, " mac_idx"},   32'(o_mac_idx),   0);
    chk({tag, " out_valid"}, 32'(o_out_valid), 0);
    chk({tag, " out_sel"},   32'(o_out_sel),   0);
    chk({tag, " busy"},      32'(o_busy),      0);
    chk({tag, " done"},      32'(o_done),      0);
  endtask

  // Starts a job and checks every output in every cycle until one cycle past done.
  // Optional: ready low for st_len cycles at beat st_beat; ena low for gap_len
  // cycles while load index gap_idx is shown; a foreign start pulse at cycle poke_c.
  task automatic run_job(input string tag, input int cin, input int cout,
                         input int st_beat, input int st_len,
                         input int gap_idx, input int gap_len, input int poke_c);
    int ld_end, cp_end, op_end, dn_c, j;
    int le, li, me, mc, mi, ov, os;
    string t;
    ld_end = (cout + 1) * 2 + gap_len;
    cp_end = ld_end + cin + 1;
    op_end = cp_end + cout + 1 + st_len;
    dn_c   = op_end + 1;
    i_cfg_in  = 4'(cin);
    i_cfg_out = 3'(cout);
    i_start   = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 1; c <= dn_c + 1; c++) begin
      le = (c <= ld_end && !(c > gap_idx + 1 && c <= gap_idx + 1 + gap_len)) ? 1 : 0;
      li = (c > ld_end) ? -1 :
           (c <= gap_idx + 1) ? c - 1 :
           (c <= gap_idx + 1 + gap_len) ? gap_idx : c - 1 - gap_len;
      me = (c > ld_end && c <= cp_end) ? 1 : 0;
      mc = (c == ld_end + 1) ? 1 : 0;
      mi = me ? c - ld_end - 1 : -1;
      j  = c - cp_end - 1;
      ov = (c > cp_end && c <= op_end) ? 1 : 0;
      os = !ov ? -1 : (j < st_beat) ? j : (j < st_beat + st_len) ? st_beat : j - st_len;
      t = $sformatf("%s c%0d", tag, c);
      chk({t, " load_en"},   32'(o_load_en),   le);
      chk({t, " load_idx"},  32'(o_load_idx),  li);
      chk({t, " mac_en"},    32'(o_mac_en),    me);
      chk({t, " mac_clr"},   32'(o_mac_clr),   mc);
      chk({t, " mac_idx"},   32'(o_mac_idx),   mi);
      chk({t, " out_valid"}, 32'(o_out_valid), ov);
      chk({t, " out_sel"},   32'(o_out_sel),   os);
      chk({t, " busy"},      32'(o_busy),      (c <= dn_c) ? 1 : 0);
      chk({t, " done"},      32'(o_done),      (c == dn_c) ? 1 : 0);
      ena         = (c > gap_idx && c <= gap_idx + gap_len) ? 1'b0 : 1'b1;
      i_out_ready = (ov == 1 && j >= st_beat && j < st_beat + st_len) ? 1'b0 : 1'b1;
      if (c == poke_c) begin
        i_start   = 1'b1;
        i_cfg_in  = 4'(15 - cin);
        i_cfg_out = 3'(7 - cout);
      end else begin
        i_start = 1'b0;
      end
      tick();
    end
    ena         = 1'b1;
    i_out_ready = 1'b1;
    i_start     = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    ena         = 1'b1;
    i_start     = 1'b0;
    i_abort     = 1'b0;
    i_cfg_in    = 4'd0;
    i_cfg_out   = 3'd0;
    i_out_ready = 1'b1;
    tick();
    tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();
    chk_zero("idle");

    // Full-size job, ready tied high.
    run_job("full", 15, 7, 0, 0, 99, 0, -1);
    // Minimum job.
    run_job("min", 0, 0, 0, 0, 99, 0, -1);
    // Consumer stalls three cycles on beat 2.
    run_job("stall", 3, 3, 2, 3, 99, 0, -1);
    // Global enable low for two cycles at load index 5.
    run_job("freeze", 3, 3, 0, 0, 5, 2, -1);

    // Abort at compute index 4.
    i_cfg_in  = 4'd7;
    i_cfg_out = 3'd1;
    i_start   = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (8) tick();
    chk("abort pre mac_en",  32'(o_mac_en),  1);
    chk("abort pre mac_idx", 32'(o_mac_idx), 4);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("abort load_en",   32'(o_load_en),   0);
    chk("abort mac_en",    32'(o_mac_en),    0);
    chk("abort mac_clr",   32'(o_mac_clr),   0);
    chk("abort out_valid", 32'(o_out_valid), 0);
    chk("abort busy",      32'(o_busy),      0);
    chk("abort done",      32'(o_done),      0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("abort after%0d done", k), 32'(o_done),   0);
      chk($sformatf("abort after%0d busy", k), 32'(o_busy),   0);
      chk($sformatf("abort after%0d mac", k),  32'(o_mac_en), 0);
    end
    // Abort wins over a simultaneous start.
    i_start = 1'b1;
    i_abort = 1'b1;
    tick();
    i_start = 1'b0;
    i_abort = 1'b0;
    chk("abort+start busy",    32'(o_busy),    0);
    chk("abort+start load_en", 32'(o_load_en), 0);
    run_job("post_abort", 7, 1, 0, 0, 99, 0, -1);

    // Start with new config during COMPUTE is ignored.
    run_job("poke", 3, 1, 0, 0, 99, 0, 6);

    // Reset during OUTPUT.
    i_cfg_in  = 4'd1;
    i_cfg_out = 3'd3;
    i_start   = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (11) tick();
    chk("rst_mid pre valid", 32'(o_out_valid), 1);
    chk("rst_mid pre sel",   32'(o_out_sel),   1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_zero("rst_mid");
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rst_mid after%0d done", k), 32'(o_done), 0);
      chk($sformatf("rst_mid after%0d busy", k), 32'(o_busy), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
